i3c_bus_input_filter: RTL
=========================

# i3c_bus_input_filter

Input conditioning stage between the I3C pad buffers and the I3C controller core. It synchronizes the raw SCL/SDA pad inputs into `clk_i` and rejects spikes shorter than a programmable number of cycles. It decodes bus conditions (START, Repeated START, STOP, SCL edges) and runs the bus-free and bus-idle timers. Its filtered lines and event pulses feed the core's `i3c_scl_i` / `i3c_sda_i` path and the bus FSM.

## Interface
Parameters:
- `SyncStages`, 2: synchronizer flops per line; minimum 2.
- `FilterCntW`, 4: width of the spike-filter counter and `filter_cycles_i`.
- `IdleCntW`, 20: width of the bus-free/idle counter and its thresholds.

Ports:
- `clk_i`  in  1  core clock; the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `scl_i`  in  1  raw SCL from pad, asynchronous.
- `sda_i`  in  1  raw SDA from pad, asynchronous.
- `filter_cycles_i`  in  FilterCntW  spike-filter threshold N; a change must persist N+1 cycles.
- `t_bus_free_i`  in  IdleCntW  bus-free threshold, in cycles.
- `t_bus_idle_i`  in  IdleCntW  bus-idle threshold, in cycles; software sets it ≥ `t_bus_free_i`.
- `scl_o`, `sda_o`  out  1  filtered lines.
- `scl_posedge_o`, `scl_negedge_o`  out  1  single-cycle SCL edge pulses.
- `start_det_o`, `rstart_det_o`, `stop_det_o`  out  1  single-cycle condition pulses.
- `bus_busy_o`  out  1  set between START and STOP.
- `bus_free_o`, `bus_idle_o`  out  1  level flags from the idle timer.

## Operation
- Reset values:
  - sync chains, `scl_o`, `sda_o`: 1.
  - all pulses, `bus_busy_o`, `bus_free_o`, `bus_idle_o`: 0.
  - filter and idle counters: 0.
- Synchronizer:
  - `SyncStages` flops per line; the last stage is `scl_s` / `sda_s`.
- Spike filter, per line, independent:
  - If `x_s == x_o`, the counter clears.
  - Otherwise, if counter == `filter_cycles_i`, `x_o <= x_s` and the counter clears; else the counter increments.
  - Any reversal before the threshold discards the pending change.
  - `filter_cycles_i` is sampled every cycle; lowering it mid-count takes effect immediately, using the `>=` compare.
- Edge/condition decode:
  - Registered on the same clock edge that updates `scl_o` / `sda_o`, using the old and next filtered values.
  - `scl_posedge_o` / `scl_negedge_o`: SCL 0→1 / 1→0.
  - SDA 1→0 with SCL high in both the old and next values:
    - `start_det_o` if `bus_busy_o` is 0, else `rstart_det_o`.
    - Sets `bus_busy_o`.
  - SDA 0→1 with SCL high in both the old and next values: `stop_det_o`; clears `bus_busy_o`.
  - SCL and SDA changing on the same cycle: edge pulses only, no condition.
- Idle timer:
  - Increments while `scl_o & sda_o` and `bus_busy_o` is 0.
  - Saturates at all-ones.
  - Clears on any filtered low, and on START or Repeated START.
  - `bus_free_o` = count ≥ `t_bus_free_i`; `bus_idle_o` = count ≥ `t_bus_idle_i`.
  - Both flags are registered.
- Lost-STOP recovery:
  - While `bus_busy_o` is 1 with both lines high, a separate count runs against `t_bus_idle_i`.
  - On reaching it, `bus_busy_o` clears and the idle timer restarts from 0.
- Threshold 0: a flag asserts on the first cycle after both lines are high and the bus is not busy.

## Timing
- Raw change held stable → `x_o` updates after `SyncStages + filter_cycles_i + 1` cycles.
- Edge/condition pulses appear in the same cycle as the `x_o` update and last exactly 1 cycle.
- `bus_busy_o` changes in the cycle after the `start_det_o` / `stop_det_o` pulse.
- Idle flags assert 1 cycle after the counter meets the threshold.
- Reset asserted mid-transfer: all state returns to reset values asynchronously; no pulse is emitted on release.
- After release, the first decode uses the synchronized levels. A line sampled low yields only a `negedge` pulse, never a condition.

## Configuration
- `I3C_SPIKE_FILTER_EN` defined: the spike filter is present as described.
- Not defined:
  - `x_o` is the registered `x_s`, with latency `SyncStages + 1`.
  - `filter_cycles_i` is ignored and no filter counters are built.
  - Decode and timers are unchanged.

## Test plan
- `filter_cycles_i`=3, SDA low pulse of 3 `clk_i` cycles with SCL high → `sda_o` stays 1, no pulses. Pulse of 4 cycles → `start_det_o` once, `bus_busy_o` set.
- START, SCL toggled 9 times, second SDA fall with SCL high → one `start_det_o`, 9 `scl_posedge_o`, one `rstart_det_o`; then SDA rise with SCL high → `stop_det_o`, `bus_busy_o`=0.
- After STOP, `t_bus_free_i`=10, `t_bus_idle_i`=50, lines held high → `bus_free_o` rises 11 cycles after the `stop_det_o` cycle and `bus_idle_o` 51 cycles after. A 1-cycle-over-filter SCL low at cycle 30 clears both flags.
- SCL and SDA raw falling on the same cycle → `scl_negedge_o` only, no `start_det_o`.
- START, then both lines held high with no STOP for `t_bus_idle_i`=50 → `bus_busy_o` clears; the next SDA fall gives `start_det_o`, not `rstart_det_o`.
- `rst_i` pulsed while `bus_busy_o`=1 and SDA low → all outputs at reset values; after release, `sda_o` falls with no condition pulse.

Source files
------------

// File: rtl/i3c_bus_input_filter.sv
// I3C pad input conditioning: synchronizer, spike filter, bus condition decode, idle timers.
// Define I3C_SPIKE_FILTER_EN to build the programmable spike filter.
module i3c_bus_input_filter #(
    parameter int SyncStages = 2,
    parameter int FilterCntW = 4,
    parameter int IdleCntW   = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    input  logic [FilterCntW-1:0] filter_cycles_i,
    input  logic [IdleCntW-1:0]   t_bus_free_i,
    input  logic [IdleCntW-1:0]   t_bus_idle_i,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic                  scl_posedge_o,
    output logic                  scl_negedge_o,
    output logic                  start_det_o,
    output logic                  rstart_det_o,
    output logic                  stop_det_o,
    output logic                  bus_busy_o,
    output logic                  bus_free_o,
    output logic                  bus_idle_o
);

    logic [SyncStages-1:0] scl_sync, sda_sync, fill;
    logic                  scl_s, sda_s, scl_nxt, sda_nxt;
    logic                  armed, cond_ok, both_high, lost_stop;
    logic                  idle_clr, idle_inc;
    logic [IdleCntW-1:0]   idle_cnt, idle_cnt_nxt, hung_cnt;

    assign scl_s = scl_sync[SyncStages-1];
    assign sda_s = sda_sync[SyncStages-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            fill     <= '0;
        end else begin
            scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
            sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
            fill     <= {fill[SyncStages-2:0], 1'b1};
        end
    end

`ifdef I3C_SPIKE_FILTER_EN
    logic [FilterCntW-1:0] scl_cnt, sda_cnt;
    logic                  scl_take, sda_take;

    assign scl_take = (scl_s != scl_o) && (scl_cnt >= filter_cycles_i);
    assign sda_take = (sda_s != sda_o) && (sda_cnt >= filter_cycles_i);
    assign scl_nxt  = scl_take ? scl_s : scl_o;
    assign sda_nxt  = sda_take ? sda_s : sda_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_cnt <= (scl_s == scl_o || scl_take) ? '0 : scl_cnt + 1'b1;
            sda_cnt <= (sda_s == sda_o || sda_take) ? '0 : sda_cnt + 1'b1;
        end
    end
`else
    logic unused_filter;

    assign unused_filter = ^filter_cycles_i;
    assign scl_nxt       = scl_s;
    assign sda_nxt       = sda_s;
`endif

    // Conditions stay masked until both lines have settled on real samples after reset
    assign cond_ok   = armed & scl_o & scl_nxt & (sda_o ^ sda_nxt);
    assign both_high = scl_o & sda_o;
    assign lost_stop = bus_busy_o & both_high & (hung_cnt >= t_bus_idle_i);
    assign idle_clr  = ~both_high | start_det_o | rstart_det_o | lost_stop;
    assign idle_inc  = ~idle_clr & ~bus_busy_o;

    always_comb begin
        idle_cnt_nxt = idle_cnt;
        if (idle_clr) begin
            idle_cnt_nxt = '0;
        end else if (idle_inc && idle_cnt != '1) begin
            idle_cnt_nxt = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_o         <= 1'b1;
            sda_o         <= 1'b1;
            armed         <= 1'b0;
            scl_posedge_o <= 1'b0;
            scl_negedge_o <= 1'b0;
            start_det_o   <= 1'b0;
            rstart_det_o  <= 1'b0;
            stop_det_o    <= 1'b0;
        end else begin
            scl_o         <= scl_nxt;
            sda_o         <= sda_nxt;
            armed         <= armed | (fill[SyncStages-1] &
                             (scl_nxt == scl_s) & (sda_nxt == sda_s));
            scl_posedge_o <= ~scl_o & scl_nxt;
            scl_negedge_o <= scl_o & ~scl_nxt;
            start_det_o   <= cond_ok & sda_o & ~bus_busy_o;
            rstart_det_o  <= cond_ok & sda_o & bus_busy_o;
            stop_det_o    <= cond_ok & ~sda_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_busy_o <= 1'b0;
            bus_free_o <= 1'b0;
            bus_idle_o <= 1'b0;
            idle_cnt   <= '0;
            hung_cnt   <= '0;
        end else begin
            if (start_det_o || rstart_det_o) begin
                bus_busy_o <= 1'b1;
            end else if (stop_det_o || lost_stop) begin
                bus_busy_o <= 1'b0;
            end
            idle_cnt   <= idle_cnt_nxt;
            bus_free_o <= idle_inc & (idle_cnt_nxt >= t_bus_free_i);
            bus_idle_o <= idle_inc & (idle_cnt_nxt >= t_bus_idle_i);
            // Busy with both lines high and no STOP seen: treat as a lost STOP
            if (bus_busy_o && both_high && !lost_stop) begin
                if (hung_cnt != '1) begin
                    hung_cnt <= hung_cnt + 1'b1;
                end
            end else begin
                hung_cnt <= '0;
            end
        end
    end

endmodule
